// File: rtl/score_packer_if.sv
// Handshake and packed-frame bundle between the score stream, the packer and the argmax stage.
// The packer sits on the slave modport; the master modport is the surrounding environment.
interface score_packer_if #(
  parameter int N_SCORES = 10,
  parameter int SCORE_W  = 8
);
  logic                         s_valid;
  logic                         s_ready;
  logic [SCORE_W-1:0]           s_score;
  logic                         s_last;
  logic [N_SCORES*SCORE_W-1:0]  out_bus;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output s_valid, s_score, s_last, out_ready,
    input  s_ready, out_bus, out_valid
  );

  modport slave (
    input  s_valid, s_score, s_last, out_ready,
    output s_ready, out_bus, out_valid
  );
endinterface

// File: rtl/score_packer.sv
// Collects N_SCORES serial scores into one wide frame and holds it until the argmax stage takes it.
// Framing errors (s_last early or missing) raise a sticky flag; flush aborts the frame in progress.
module score_packer #(
  parameter int N_SCORES = 10,
  parameter int SCORE_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  score_packer_if.slave       bus,
  output logic [15:0]         frame_cnt,
  output logic                err_len
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam int IDX_W = (N_SCORES > 1) ? $clog2(N_SCORES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SCORES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [SCORE_W-1:0] lanes [N_SCORES];
  logic               accept;
  logic               handoff;
  logic               at_last;

  // Both handshake outputs depend only on state, gated so they read 0 while reset is held.
  assign bus.s_ready   = rst_n && (state == FILL);
  assign bus.out_valid = rst_n && (state == HOLD);
  assign accept        = bus.s_valid && bus.s_ready;
  assign handoff       = bus.out_valid && bus.out_ready;
  assign at_last       = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (accept && at_last) state_nxt = HOLD;
        HOLD:    if (handoff) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // A beat flagged s_last before the final lane aborts the frame, but the lane is still written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      err_len   <= 1'b0;
      frame_cnt <= 16'd0;
      for (int k = 0; k < N_SCORES; k++) begin
        lanes[k] <= '0;
      end
    end else if (flush) begin
      idx <= '0;
    end else begin
      if (accept) begin
        lanes[idx] <= bus.s_score;
        idx        <= (at_last || bus.s_last) ? '0 : idx + 1'b1;
        if (bus.s_last != at_last) begin
          err_len <= 1'b1;
        end
      end
      if (handoff) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    bus.out_bus = '0;
    for (int k = 0; k < N_SCORES; k++) begin
      bus.out_bus[k*SCORE_W +: SCORE_W] = lanes[k];
    end
  end

endmodule

// File: tb/tb_score_packer.sv
// Randomised and directed bench for score_packer, checked every cycle against a frame-level model.
module tb_score_packer;
  localparam int N  = 10;
  localparam int SW = 8;
  localparam int BW = N * SW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] frame_cnt;
  logic        err_len;

  score_packer_if #(.N_SCORES(N), .SCORE_W(SW)) bus ();

  score_packer #(.N_SCORES(N), .SCORE_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: whether a finished frame is waiting, how many beats of the current frame are in, lane contents.
  bit          m_hold;
  int          m_fill;
  int          m_cnt;
  bit          m_err;
  logic [SW-1:0] m_lanes [N];

  function automatic logic [BW-1:0] modelBus();
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < N; k++) b[k*SW +: SW] = m_lanes[k];
    return b;
  endfunction

  task automatic compare(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    m_hold = 1'b0;
    m_fill = 0;
    m_cnt  = 0;
    m_err  = 1'b0;
    for (int k = 0; k < N; k++) m_lanes[k] = '0;
  endtask

  task automatic modelStep(input bit v, input logic [SW-1:0] sc, input bit l, input bit f, input bit r);
    if (f) begin
      m_hold = 1'b0;
      m_fill = 0;
    end else if (m_hold) begin
      if (r) begin
        m_hold = 1'b0;
        m_cnt  = (m_cnt + 1) % 65536;
      end
    end else if (v) begin
      m_lanes[m_fill] = sc;
      if (m_fill == N - 1) begin
        if (!l) m_err = 1'b1;
        m_hold = 1'b1;
        m_fill = 0;
      end else if (l) begin
        m_err  = 1'b1;
        m_fill = 0;
      end else begin
        m_fill++;
      end
    end
  endtask

  task automatic checkOutput();
    compare("s_ready",   BW'(bus.s_ready),   BW'(!m_hold));
    compare("out_valid", BW'(bus.out_valid), BW'(m_hold));
    compare("frame_cnt", BW'(frame_cnt),     BW'(m_cnt));
    compare("err_len",   BW'(err_len),       BW'(m_err));
    if (m_hold) compare("out_bus", bus.out_bus, modelBus());
  endtask

  // One clock: check outputs on the falling edge, drive new inputs, advance the model at the rising edge.
  task automatic applyStimulus(input bit v, input logic [SW-1:0] sc, input bit l, input bit f, input bit r);
    @(negedge clk);
    checkOutput();
    bus.s_valid   = v;
    bus.s_score   = sc;
    bus.s_last    = l;
    bus.out_ready = r;
    flush         = f;
    @(posedge clk);
    modelStep(v, sc, l, f, r);
  endtask

  localparam logic [BW-1:0] REF_FRAME = 80'hA0908070605040302010;

  initial begin
    bit v, l, f, r;
    logic [SW-1:0] sc;
    bus.s_valid   = 1'b0;
    bus.s_score   = '0;
    bus.s_last    = 1'b0;
    bus.out_ready = 1'b0;
    modelReset();

    #12;
    compare("rst_s_ready",   BW'(bus.s_ready),   BW'(1'b0));
    compare("rst_out_valid", BW'(bus.out_valid), BW'(1'b0));
    compare("rst_out_bus",   bus.out_bus,        '0);
    compare("rst_frame_cnt", BW'(frame_cnt),     BW'(16'd0));
    compare("rst_err_len",   BW'(err_len),       BW'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 compare("ready_after_reset", BW'(bus.s_ready), BW'(1'b1));

    // Reference frame, downstream always ready.
    for (int i = 0; i < N; i++) applyStimulus(1'b1, SW'(16 * (i + 1)), i == N - 1, 1'b0, 1'b1);
    #1;
    compare("ref_out_valid", BW'(bus.out_valid), BW'(1'b1));
    compare("ref_out_bus",   bus.out_bus,        REF_FRAME);
    compare("ref_cnt_before_handoff", BW'(frame_cnt), BW'(16'd0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    compare("ref_cnt_after_handoff", BW'(frame_cnt), BW'(16'd1));
    compare("ref_err_len", BW'(err_len), BW'(1'b0));

    // Same frame held for five cycles with upstream still pushing.
    for (int i = 0; i < N; i++) applyStimulus(1'b1, SW'(16 * (i + 1)), i == N - 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    #1;
    compare("hold_out_bus", bus.out_bus, REF_FRAME);
    compare("hold_s_ready", BW'(bus.s_ready), BW'(1'b0));
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    #1 compare("hold_cnt", BW'(frame_cnt), BW'(16'd2));

    // Early s_last on beat 4, then a clean frame from lane 0.
    for (int i = 1; i < 4; i++) applyStimulus(1'b1, SW'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    #1;
    compare("early_last_err", BW'(err_len), BW'(1'b1));
    compare("early_last_no_valid", BW'(bus.out_valid), BW'(1'b0));
    for (int i = 0; i < N; i++) applyStimulus(1'b1, SW'(8'hC0 + i), i == N - 1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1 compare("clean_after_err_cnt", BW'(frame_cnt), BW'(16'd3));

    // Flush coinciding with the last beat.
    for (int i = 0; i < N - 1; i++) applyStimulus(1'b1, SW'(8'h30 + i), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    #1;
    compare("flush_no_valid", BW'(bus.out_valid), BW'(1'b0));
    compare("flush_cnt", BW'(frame_cnt), BW'(16'd3));
    for (int i = 0; i < N; i++) applyStimulus(1'b1, SW'(8'h70 + i), i == N - 1, 1'b0, 1'b0);

    // Asynchronous reset while a frame is held.
    #3 rst_n = 1'b0;
    #1;
    compare("async_out_valid", BW'(bus.out_valid), BW'(1'b0));
    compare("async_s_ready",   BW'(bus.s_ready),   BW'(1'b0));
    compare("async_out_bus",   bus.out_bus,        '0);
    compare("async_frame_cnt", BW'(frame_cnt),     BW'(16'd0));
    bus.s_valid   = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    modelReset();
    #3 rst_n = 1'b1;

    // Random traffic with occasional framing errors and flushes.
    for (int n = 0; n < 4000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      sc = SW'($urandom);
      l  = (!m_hold && m_fill == N - 1) ^ ($urandom_range(0, 49) == 0);
      f  = ($urandom_range(0, 39) == 0);
      r  = $urandom_range(0, 1) != 0;
      applyStimulus(v, sc, l, f, r);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/score_packer.md
SCORE_PACKER -- requirements
Module: score_packer

Interface
REQ-001 Parameter N_SCORES, default 10, meaning number of output-layer scores per frame.
REQ-002 Parameter SCORE_W, default 8, meaning width of one unsigned score.
REQ-003 clk  input  1  meaning the single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 s_valid  input  1  meaning upstream score beat valid.
REQ-006 s_ready  output  1  meaning packer accepts a beat this cycle.
REQ-007 s_score  input  SCORE_W  meaning one neuron score, in neuron order 0 first.
REQ-008 s_last  input  1  meaning upstream marks the final beat of a frame.
REQ-009 flush  input  1  meaning synchronous abort of the frame in progress.
REQ-010 out_bus  output  N_SCORES*SCORE_W  meaning packed frame for the argmax stage; score k in bits [k*SCORE_W+SCORE_W-1 : k*SCORE_W].
REQ-011 out_valid  output  1  meaning out_bus holds a complete frame.
REQ-012 out_ready  input  1  meaning downstream consumed the frame.
REQ-013 frame_cnt  output  16  meaning count of frames handed off.
REQ-014 err_len  output  1  meaning sticky framing-error flag.

Function
REQ-015 Beat accepted iff s_valid && s_ready at a rising edge; frame handed off iff out_valid && out_ready.
REQ-016 FSM states FILL and HOLD; s_ready = (state==FILL); out_valid = (state==HOLD); both combinational from state.
REQ-017 Index counter idx, width ceil(log2(N_SCORES)), counts 0..N_SCORES-1 within a frame.
REQ-018 FILL, accepted beat: s_score written to lane idx of out_bus in place, idx increments.
REQ-019 FILL, accepted beat with idx==N_SCORES-1: lane written, idx returns to 0, next state HOLD; out_valid first high the following cycle (1-cycle latency from last beat).
REQ-020 Lanes not yet written in the current frame retain previous contents; out_bus meaningful only while out_valid=1.
REQ-021 HOLD: out_bus stable, s_ready=0; handoff -> next state FILL, frame_cnt increments by 1 (wraps 0xFFFF -> 0x0000).
REQ-022 No same-cycle handoff and accept: s_ready is 0 throughout HOLD, including the handoff cycle; first new beat accepted the cycle after handoff at earliest.
REQ-023 s_last high on an accepted beat with idx!=N_SCORES-1: err_len set, lane still written, frame aborted: idx -> 0, state stays FILL, no handoff.
REQ-024 s_last low on the accepted beat with idx==N_SCORES-1: err_len set, frame still completes normally (REQ-019).
REQ-025 flush high: idx -> 0, state -> FILL, lanes not altered, frame_cnt unchanged; flush overrides a simultaneous beat accept (beat discarded) and a simultaneous handoff (not counted).
REQ-026 err_len cleared only by reset.
REQ-027 s_score and s_last ignored when not accepted; no combinational path from s_valid to s_ready or from out_ready to out_valid.

Reset
REQ-028 rst_n low asynchronously forces: state FILL, idx 0, out_bus all zeros, out_valid 0, s_ready 1 (after release), frame_cnt 0, err_len 0.
REQ-029 Reset mid-frame or in HOLD discards the frame; no handoff occurs and frame_cnt stays 0.
REQ-030 While rst_n low, s_ready and out_valid SHALL both read 0.

Verification
REQ-031 Scores 0x10,0x20..0xA0 back-to-back with s_last on beat 9, out_ready=1 -> out_valid one cycle after beat 9, out_bus = 0xA0908070605040302010, frame_cnt 1, err_len 0.
REQ-032 Same frame, out_ready=0 for 5 cycles -> out_valid held, out_bus stable, s_ready 0 with s_valid=1; handoff on cycle 6, first new beat accepted cycle 7.
REQ-033 s_last asserted on beat 4 -> err_len=1, no out_valid; next 10 beats form a clean frame with frame_cnt 1.
REQ-034 flush asserted together with beat 9 -> beat discarded, state FILL, idx 0, no out_valid, frame_cnt unchanged.
REQ-035 rst_n pulsed low during HOLD -> out_bus 0, out_valid 0, frame_cnt 0 immediately, without a clock edge.
REQ-036 Force 65536 frames -> frame_cnt reads 0x0000 after last handoff, no other side effect.
